// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern recognizer path: word length, counter width
// and the serializer state encoding.
package pattern_pkg;

    localparam int SEQ_LEN = 28;
    localparam int CNT_W   = $clog2(SEQ_LEN);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic head_bit(input logic [SEQ_LEN-1:0] word, input logic lsb_first);
        return lsb_first ? word[0] : word[SEQ_LEN-1];
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Load/shift register holding the bits of a word that are still waiting to go out.
// The head bit is taken by the parent at load time, so the register starts one step ahead.
module seq_shift_reg
    import pattern_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic               lsb_first,
    input  logic [SEQ_LEN-1:0] d,
    output logic               out_bit
);

    logic [SEQ_LEN-1:0] pend_q;
    logic               lsb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            lsb_q  <= 1'b0;
        end else if (load) begin
            lsb_q  <= lsb_first;
            pend_q <= lsb_first ? {1'b0, d[SEQ_LEN-1:1]} : {d[SEQ_LEN-2:0], 1'b0};
        end else if (shift) begin
            pend_q <= lsb_q ? {1'b0, pend_q[SEQ_LEN-1:1]} : {pend_q[SEQ_LEN-2:0], 1'b0};
        end
    end

    assign out_bit = lsb_q ? pend_q[0] : pend_q[SEQ_LEN-1];

endmodule

// File: rtl/pattern_seq_serializer.sv
// Serializes a parallel pattern word onto X one bit per clock, holding TYPE stable
// for the whole word and pulsing done in the single gap cycle that follows it.
module pattern_seq_serializer
    import pattern_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEQ_LEN-1:0] in_seq,
    input  logic               in_type,
    input  logic               in_lsb_first,
    input  logic               abort,
    output logic               X,
    output logic               TYPE,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   bit_idx
);

    state_e           state_q;
    logic             x_q;
    logic             type_q;
    logic             xv_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] idx_q;

    logic accept_d;
    logic last_bit_d;
    logic advance_d;
    logic next_bit_d;

    assign in_ready   = (state_q == ST_IDLE);
    assign accept_d   = in_valid && in_ready;
    assign last_bit_d = (idx_q == LAST_IDX);
    assign advance_d  = (state_q == ST_SHIFT) && !abort && !last_bit_d;

    seq_shift_reg u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_d),
        .shift     (advance_d),
        .lsb_first (in_lsb_first),
        .d         (in_seq),
        .out_bit   (next_bit_d)
    );

    // abort outranks the bit advance and the transition into the gap cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= 1'b0;
            type_q  <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept_d) begin
                        state_q <= ST_SHIFT;
                        x_q     <= head_bit(in_seq, in_lsb_first);
                        xv_q    <= 1'b1;
                        type_q  <= in_type;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        x_q     <= 1'b0;
                        xv_q    <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (last_bit_d) begin
                        state_q <= ST_GAP;
                        x_q     <= 1'b0;
                        xv_q    <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        x_q   <= next_bit_d;
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    x_q     <= 1'b0;
                    xv_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign X       = x_q;
    assign TYPE    = type_q;
    assign x_valid = xv_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_idx = idx_q;

    a_idx_range: assert property (@(posedge clk) disable iff (reset) idx_q <= LAST_IDX);
    a_done_quiet: assert property (@(posedge clk) disable iff (reset) done_q |-> !xv_q);
    a_busy_ready: assert property (@(posedge clk) disable iff (reset) busy_q == !in_ready);

endmodule
